// File: rtl/vga_sprite_overlay_pkg.sv
// Shared types and helpers for the VGA sprite-overlay stage.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  typedef logic [23:0] bgr_t;

  // Move a coordinate by +inc/-dec and saturate into [0, max]; never wraps.
  function automatic int clamp_step(int pos, int inc, int dec, int max);
    int r;
    r = pos + inc - dec;
    if (r < 0) begin
      r = 0;
    end else if (r > max) begin
      r = max;
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_sprite_overlay_if.sv
// Pixel-stream and sprite-status bundle for vga_sprite_overlay.
interface vga_sprite_overlay_if
  import vga_pkg::*;
#(
  parameter int unsigned NUM_SPR  = 2,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
);
  localparam int unsigned X_W = $clog2(H_ACTIVE);
  localparam int unsigned Y_W = $clog2(V_ACTIVE);

  logic                     iBLANK_n;
  logic                     iVS;
  bgr_t                     iBGR;
  logic [4*NUM_SPR-1:0]     iDIR;
  bgr_t                     oBGR;
  logic                     oBLANK_n;
  logic                     oCOLLIDE;
  logic [NUM_SPR*X_W-1:0]   oPOS_X;
  logic [NUM_SPR*Y_W-1:0]   oPOS_Y;

  // Upstream pipeline side: drives the background stream, consumes the composite.
  modport master (
    output iBLANK_n, iVS, iBGR, iDIR,
    input  oBGR, oBLANK_n, oCOLLIDE, oPOS_X, oPOS_Y
  );

  // Overlay stage side.
  modport slave (
    input  iBLANK_n, iVS, iBGR, iDIR,
    output oBGR, oBLANK_n, oCOLLIDE, oPOS_X, oPOS_Y
  );

endinterface

// File: rtl/vga_sprite_overlay_sprite_unit.sv
// One sprite: position registers, frame-synchronous clamped motion, hit comparator.
module sprite_unit
  import vga_pkg::*;
#(
  parameter int unsigned Idx      = 0,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned SPR_SIZE = 20,
  parameter int unsigned STEP     = 1,
  parameter int unsigned X_W      = $clog2(H_ACTIVE),
  parameter int unsigned Y_W      = $clog2(V_ACTIVE)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           tick_i,
  input  logic [3:0]     dir_i,   // {right, left, up, down}
  input  logic [X_W-1:0] px_i,
  input  logic [Y_W-1:0] py_i,
  output logic           hit_o,
  output logic [X_W-1:0] pos_x_o,
  output logic [Y_W-1:0] pos_y_o
);

  localparam int XMax = int'(H_ACTIVE - SPR_SIZE);
  localparam int YMax = int'(V_ACTIVE - SPR_SIZE);
  localparam int Step = int'(STEP);
  localparam int Size = int'(SPR_SIZE);
  localparam logic [X_W-1:0] XRst = X_W'(Idx * 2 * SPR_SIZE);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  // Apply at most one move per tick, right > left > up > down.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (tick_i) begin
      if (dir_i[3]) begin
        x_d = X_W'(clamp_step(int'(x_q), Step, 0, XMax));
      end else if (dir_i[2]) begin
        x_d = X_W'(clamp_step(int'(x_q), 0, Step, XMax));
      end else if (dir_i[1]) begin
        y_d = Y_W'(clamp_step(int'(y_q), 0, Step, YMax));
      end else if (dir_i[0]) begin
        y_d = Y_W'(clamp_step(int'(y_q), Step, 0, YMax));
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q <= XRst;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Inclusive lower bound, exclusive upper bound on both axes.
  always_comb begin
    hit_o = (int'(px_i) >= int'(x_q)) && (int'(px_i) < int'(x_q) + Size) &&
            (int'(py_i) >= int'(y_q)) && (int'(py_i) < int'(y_q) + Size);
  end

  assign pos_x_o = x_q;
  assign pos_y_o = y_q;

endmodule

// File: rtl/vga_sprite_overlay.sv
// Sprite-overlay stage: pixel counters, frame divider, sprite priority mux,
// one-cycle output registers. Optional overlap flag enabled by SPRITE_COLLIDE_EN.
module vga_sprite_overlay
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned SPR_SIZE   = 20,
  parameter int unsigned NUM_SPR    = 2,
  parameter int unsigned STEP       = 1,
  parameter int unsigned FRAME_DIV  = 1,
  // Slice i (bits 24i+23:24i) is sprite i: pink, green, red, blue.
  parameter logic [4*24-1:0] SPR_COLORS = {24'h0000FF, 24'hFF0000, 24'h00FF00, 24'hFFC0CB}
) (
  input logic                 iVGA_CLK,
  input logic                 iRST,
  vga_sprite_overlay_if.slave bus
);

  localparam int unsigned X_W  = $clog2(H_ACTIVE);
  localparam int unsigned Y_W  = $clog2(V_ACTIVE);
  localparam int unsigned FC_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic                   vs_q;
  logic                   frame_start;
  logic                   tick;
  logic [X_W-1:0]         px_q, px_d;
  logic [Y_W-1:0]         py_q, py_d;
  logic [FC_W-1:0]        fc_q, fc_d;
  logic [NUM_SPR-1:0]     hit;
  logic [NUM_SPR*X_W-1:0] pos_x;
  logic [NUM_SPR*Y_W-1:0] pos_y;
  bgr_t                   pix_d, pix_q;
  logic                   blank_q;

  assign frame_start = vs_q & ~bus.iVS;
  assign tick        = frame_start && (fc_q == FC_W'(FRAME_DIV - 1));

  // Pixel coordinates follow the active-video strobe; a frame start overrides.
  always_comb begin
    px_d = px_q;
    py_d = py_q;
    if (frame_start) begin
      px_d = '0;
      py_d = '0;
    end else if (bus.iBLANK_n) begin
      if (px_q == X_W'(H_ACTIVE - 1)) begin
        px_d = '0;
        if (py_q != Y_W'(V_ACTIVE - 1)) begin
          py_d = py_q + Y_W'(1);
        end
      end else begin
        px_d = px_q + X_W'(1);
      end
    end
  end

  // Frame divider: tick on the last frame of each group, then wrap.
  always_comb begin
    fc_d = fc_q;
    if (frame_start) begin
      fc_d = tick ? '0 : fc_q + FC_W'(1);
    end
  end

  // Counter, sync-edge and divider state.
  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      vs_q <= 1'b0;
      px_q <= '0;
      py_q <= '0;
      fc_q <= '0;
    end else begin
      vs_q <= bus.iVS;
      px_q <= px_d;
      py_q <= py_d;
      fc_q <= fc_d;
    end
  end

  for (genvar i = 0; i < NUM_SPR; i++) begin : g_spr
    sprite_unit #(
      .Idx      (i),
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE),
      .SPR_SIZE (SPR_SIZE),
      .STEP     (STEP),
      .X_W      (X_W),
      .Y_W      (Y_W)
    ) u_spr (
      .clk_i   (iVGA_CLK),
      .rst_i   (iRST),
      .tick_i  (tick),
      .dir_i   (bus.iDIR[4*i +: 4]),
      .px_i    (px_q),
      .py_i    (py_q),
      .hit_o   (hit[i]),
      .pos_x_o (pos_x[i*X_W +: X_W]),
      .pos_y_o (pos_y[i*Y_W +: Y_W])
    );
  end

  assign bus.oPOS_X = pos_x;
  assign bus.oPOS_Y = pos_y;

  // Priority mux: walk from the highest index down so the lowest hitting sprite wins.
  always_comb begin
    pix_d = bus.iBGR;
    for (int i = int'(NUM_SPR) - 1; i >= 0; i--) begin
      if (hit[i]) begin
        pix_d = SPR_COLORS[24*i +: 24];
      end
    end
    if (!bus.iBLANK_n) begin
      pix_d = '0;
    end
  end

  // Output registers give the one-cycle pixel latency.
  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      pix_q   <= '0;
      blank_q <= 1'b0;
    end else begin
      pix_q   <= pix_d;
      blank_q <= bus.iBLANK_n;
    end
  end

  assign bus.oBGR     = pix_q;
  assign bus.oBLANK_n = blank_q;

`ifdef SPRITE_COLLIDE_EN
  logic overlap;
  logic sticky_q;
  logic collide_q;

  assign overlap = bus.iBLANK_n && ($countones(hit) >= 2);

  // Sticky overlap per frame; an overlap on the frame-start cycle belongs to the new frame.
  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      sticky_q  <= 1'b0;
      collide_q <= 1'b0;
    end else if (frame_start) begin
      collide_q <= sticky_q;
      sticky_q  <= overlap;
    end else begin
      sticky_q  <= sticky_q | overlap;
    end
  end

  assign bus.oCOLLIDE = collide_q;
`else
  assign bus.oCOLLIDE = 1'b0;
`endif

endmodule
